// File: rtl/add_seq_arb.sv
// Multi-word add/subtract sequencer: two requesters share one 32-bit
// carry-select adder through a round-robin arbiter, one limb per clock.

module csadd32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // Each byte computes both carry-in outcomes in parallel; the incoming carry only selects.
  for (genvar g = 0; g < 4; g++) begin : gBlk
    logic [8:0] sumNoCarry;
    logic [8:0] sumWithCarry;

    assign sumNoCarry   = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]};
    assign sumWithCarry = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]} + 9'd1;
    assign s[g*8 +: 8]  = carry[g] ? sumWithCarry[7:0] : sumNoCarry[7:0];
    assign carry[g+1]   = carry[g] ? sumWithCarry[8]   : sumNoCarry[8];
  end

  assign cout = carry[4];

endmodule

module add_seq_arb #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WORDS*32-1:0] req0_a,
  input  logic [WORDS*32-1:0] req0_b,
  input  logic               req0_sub,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WORDS*32-1:0] req1_a,
  input  logic [WORDS*32-1:0] req1_b,
  input  logic               req1_sub,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WORDS*32-1:0] resp_sum,
  output logic               resp_cout,
  output logic               busy
);

  localparam int W  = WORDS * 32;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  opA_q, opA_d;
  logic [W-1:0]  opB_q, opB_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sub_q, sub_d;
  logic          id_q, id_d;
  logic          prio_q, prio_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          valid_q, valid_d;

  logic          gnt0, gnt1;
  logic          selSub;
  logic [W-1:0]  selA, selB;
  logic [31:0]   addA, addB, addS;
  logic          addCin, addCout;

  // A lone requester always wins; on contention the priority pointer decides.
  assign gnt0 = req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = req1_valid && (!req0_valid ||  prio_q);

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;

  assign selA   = gnt1 ? req1_a   : req0_a;
  assign selB   = gnt1 ? req1_b   : req0_b;
  assign selSub = gnt1 ? req1_sub : req0_sub;

  // B is stored pre-inverted for subtraction, so the adder only ever sees registers.
  assign addA   = opA_q[idx_q*32 +: 32];
  assign addB   = opB_q[idx_q*32 +: 32];
  assign addCin = (idx_q == '0) ? sub_q : carry_q;

  csadd32 uAdder (
    .a    (addA),
    .b    (addB),
    .cin  (addCin),
    .s    (addS),
    .cout (addCout)
  );

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    id_d    = id_q;
    prio_d  = prio_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          opA_d   = selA;
          opB_d   = selB ^ {W{selSub}};
          sub_d   = selSub;
          id_d    = gnt1;
          prio_d  = !gnt1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*32 +: 32] = addS;
        carry_d = addCout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = addCout;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = cout_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_add_seq_arb.sv
// Directed bench for add_seq_arb (WORDS=4): vector table plus hand-written
// arbitration, backpressure and mid-operation reset sequences.

module tb_add_seq_arb;

  localparam int WORDS = 4;
  localparam int W = WORDS * 32;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0Valid, req0Ready, req0Sub;
  logic [W-1:0] req0A, req0B;
  logic         req1Valid, req1Ready, req1Sub;
  logic [W-1:0] req1A, req1B;
  logic         respValid, respReady, respId, respCout, busy;
  logic [W-1:0] respSum;

  int totalChecks = 0;
  int badChecks   = 0;

  vec_t vecs[6];

  add_seq_arb #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0Valid),
    .req0_ready (req0Ready),
    .req0_a     (req0A),
    .req0_b     (req0B),
    .req0_sub   (req0Sub),
    .req1_valid (req1Valid),
    .req1_ready (req1Ready),
    .req1_a     (req1A),
    .req1_b     (req1B),
    .req1_sub   (req1Sub),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_id    (respId),
    .resp_sum   (respSum),
    .resp_cout  (respCout),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    #1;
  endtask

  // Waits for resp_valid, returns edges elapsed since the handshake and how many
  // cycles showed a ready or a dropped busy while the operation was in flight.
  task automatic waitResponse(output int lat, output int badRun);
    lat = 0;
    badRun = 0;
    while (!respValid && lat < 20) begin
      if (req0Ready || req1Ready || !busy) badRun++;
      stepCycle();
      lat++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int lat, badRun, tries;
    logic got;
    got = 1'b0;
    if (v.id) begin
      req1A = v.a; req1B = v.b; req1Sub = v.sub; req1Valid = 1'b1;
    end else begin
      req0A = v.a; req0B = v.b; req0Sub = v.sub; req0Valid = 1'b1;
    end
    for (tries = 0; tries < 10 && !got; tries++) begin
      #1;
      if ((v.id ? req1Ready : req0Ready) === 1'b1) got = 1'b1;
      else stepCycle();
    end
    checkOutput({name, "_accept"}, W'(got), W'(1));
    stepCycle();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    req0A = ~v.a; req0B = ~v.b; req0Sub = ~v.sub;
    req1A = ~v.a; req1B = ~v.b; req1Sub = ~v.sub;
    if (!got) return;
    waitResponse(lat, badRun);
    checkOutput({name, "_latency"}, W'(lat), W'(WORDS));
    checkOutput({name, "_runQuiet"}, W'(badRun), W'(0));
    checkOutput({name, "_sum"}, respSum, v.sum);
    checkOutput({name, "_cout"}, W'(respCout), W'(v.cout));
    checkOutput({name, "_id"}, W'(respId), W'(v.id));
    respReady = 1'b1;
    stepCycle();
    respReady = 1'b0;
    checkOutput({name, "_validDrop"}, W'(respValid), W'(0));
    checkOutput({name, "_idleAgain"}, W'(busy), W'(0));
  endtask

  initial begin
    int lat, badRun, tries;
    logic [W-1:0] heldSum;
    logic heldCout, heldId, got;

    vecs[0] = '{1'b0, W'(32'hFFFF_FFFF), W'(1), 1'b0, W'(64'h1_0000_0000), 1'b0};
    vecs[1] = '{1'b1, {W{1'b1}}, W'(1), 1'b0, W'(0), 1'b1};
    vecs[2] = '{1'b0, W'(7), W'(5), 1'b1, W'(2), 1'b1};
    vecs[3] = '{1'b0, W'(5), W'(7), 1'b1, {{(W-1){1'b1}}, 1'b0}, 1'b0};
    vecs[4] = '{1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0,
                128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321, 1'b0};
    vecs[5] = '{1'b1, 128'h1_0000_0000_0000_0000, W'(1), 1'b1,
                128'h0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b1};

    rst = 1'b0;
    req0Valid = 1'b0; req0A = '0; req0B = '0; req0Sub = 1'b0;
    req1Valid = 1'b0; req1A = '0; req1B = '0; req1Sub = 1'b0;
    respReady = 1'b0;
    #5;
    doReset();

    checkOutput("rst_valid", W'(respValid), W'(0));
    checkOutput("rst_sum", respSum, W'(0));
    checkOutput("rst_cout", W'(respCout), W'(0));
    checkOutput("rst_id", W'(respId), W'(0));
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_readies", W'({req0Ready, req1Ready}), W'(0));

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Round robin with both requesters always asking.
    $display("[TB] arbitration sequence");
    doReset();
    req0A = W'(10);  req0B = W'(3); req0Sub = 1'b0;
    req1A = W'(100); req1B = W'(1); req1Sub = 1'b1;
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    respReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (tries = 0; tries < 10 && !got; tries++) begin
        #1;
        if (req0Ready || req1Ready) got = 1'b1;
        else stepCycle();
      end
      checkOutput($sformatf("arb%0d_accept", k), W'(got), W'(1));
      checkOutput($sformatf("arb%0d_oneReady", k), W'(req0Ready && req1Ready), W'(0));
      checkOutput($sformatf("arb%0d_grant", k), W'(req1Ready), W'(k % 2));
      stepCycle();
      waitResponse(lat, badRun);
      checkOutput($sformatf("arb%0d_runQuiet", k), W'(badRun), W'(0));
      checkOutput($sformatf("arb%0d_id", k), W'(respId), W'(k % 2));
      checkOutput($sformatf("arb%0d_sum", k), respSum, (k % 2) ? W'(99) : W'(13));
      checkOutput($sformatf("arb%0d_cout", k), W'(respCout), (k % 2) ? W'(1) : W'(0));
      stepCycle();
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    respReady = 1'b0;
    stepCycle();

    // Consumer stalls for three cycles while a new request waits.
    $display("[TB] backpressure sequence");
    doReset();
    req0A = W'(3); req0B = W'(4); req0Sub = 1'b0; req0Valid = 1'b1;
    #1;
    checkOutput("bp_accept", W'(req0Ready), W'(1));
    stepCycle();
    waitResponse(lat, badRun);
    checkOutput("bp_latency", W'(lat), W'(WORDS));
    checkOutput("bp_sum", respSum, W'(7));
    heldSum = respSum;
    heldCout = respCout;
    heldId = respId;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("bp%0d_valid", c), W'(respValid), W'(1));
      checkOutput($sformatf("bp%0d_sum", c), respSum, heldSum);
      checkOutput($sformatf("bp%0d_coutId", c), W'({respCout, respId}), W'({heldCout, heldId}));
      checkOutput($sformatf("bp%0d_ready", c), W'(req0Ready), W'(0));
    end
    respReady = 1'b1;
    stepCycle();
    respReady = 1'b0;
    checkOutput("bp_validDrop", W'(respValid), W'(0));
    checkOutput("bp_idle", W'(busy), W'(0));
    checkOutput("bp_readyBack", W'(req0Ready), W'(1));
    req0Valid = 1'b0;
    stepCycle();

    // Reset lands while limb 2 is in the adder.
    $display("[TB] reset during run");
    req1A = {W{1'b1}}; req1B = W'(1); req1Sub = 1'b0; req1Valid = 1'b1;
    #1;
    checkOutput("rr_accept", W'(req1Ready), W'(1));
    stepCycle();
    req1Valid = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rr_busyMid", W'(busy), W'(1));
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    req0A = W'(9); req0B = W'(4); req0Sub = 1'b1; req0Valid = 1'b1;
    #1;
    checkOutput("rr_valid", W'(respValid), W'(0));
    checkOutput("rr_busy", W'(busy), W'(0));
    checkOutput("rr_sum", respSum, W'(0));
    checkOutput("rr_ready0", W'(req0Ready), W'(1));
    applyStimulus('{1'b0, W'(9), W'(4), 1'b1, W'(5), 1'b1}, "rr_fresh");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
